mem_access_unit: RTL and testbench

Memory-stage access unit of the Proyecto4 processor datapath. It sits directly upstream of the 32-bit memory/writeback pipeline register. It takes load/store commands from the execute stage and runs them on a word-wide request/acknowledge data-memory bus, generating byte enables and aligned store data. It returns sign- or zero-extended load data to that register and stalls the pipeline until the access completes, aborts on misalignment, or times out.

---
 rtl/mem_access_unit_pkg.sv | 27 ++
 rtl/mem_access_unit_load_align.sv | 33 +++
 rtl/mem_access_unit.sv | 147 ++++++++++++++
 tb/tb_mem_access_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// mem_pkg: shared definitions for the memory-stage access unit.
//   - access size encodings (SZ_BYTE/SZ_HALF/SZ_WORD; 2'b11 is reserved and behaves as word)
//   - FSM state type (ST_IDLE/ST_ACCESS/ST_DONE)
//   - is_misaligned(): alignment predicate for a size and the low address bits
package mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_DONE
   } state_t;

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      logic result;
      case (size)
         SZ_BYTE: result = 1'b0;
         SZ_HALF: result = addr_lo[0];
         default: result = (addr_lo != 2'b00);
      endcase
      return result;
   endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// load_align: combinational load lane selection and extension.
// Ports:
//   bus_rdata   in  32  word returned by the data memory
//   addr_lo     in  2   byte offset of the access within the word
//   size        in  2   access size (byte/half/word, reserved = word)
//   is_unsigned in  1   1 = zero-extend, 0 = sign-extend
//   result      out 32  right-justified, extended load value
module load_align
   import mem_pkg::*;
(
   input  logic [31:0] bus_rdata,
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   output logic [31:0] result
);

   logic [31:0] lane;
   logic        sign8;
   logic        sign16;

   always_comb begin
      lane   = bus_rdata >> {addr_lo, 3'b000};
      sign8  = ~is_unsigned & lane[7];
      sign16 = ~is_unsigned & lane[15];
      case (size)
         SZ_BYTE: result = {{24{sign8}}, lane[7:0]};
         SZ_HALF: result = {{16{sign16}}, lane[15:0]};
         default: result = lane;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage load/store unit on a word-wide req/ack bus.
// Accepts one aligned command from execute, holds the bus request until ack
// or timeout, and returns extended load data to the memory/writeback register.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   mem_read, mem_write          command (read wins when both set)
//   size, is_unsigned            access size, load extension mode
//   addr, wdata                  byte address, right-justified store data
//   bus_req/we/addr/be/wdata     registered bus request fields
//   bus_ack, bus_rdata           single-cycle acknowledge with read word
//   stall                        freezes upstream while a command is in flight
//   load_data                    extended load result
//   done, misaligned, bus_timeout  one-cycle completion/abort pulses
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata,
   output logic        stall,
   output logic [31:0] load_data,
   output logic        done,
   output logic        misaligned,
   output logic        bus_timeout
);

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t      state;
   state_t      state_next;
   logic [7:0]  wait_cnt;
   logic        cmd;
   logic        cmd_misaligned;
   logic        accept;
   logic        timeout_hit;
   logic [3:0]  be_next;
   logic [31:0] wdata_next;
   logic [1:0]  lane_q;
   logic [1:0]  size_q;
   logic        unsigned_q;
   logic [31:0] aligned_rdata;

   always_comb begin
      cmd            = mem_read | mem_write;
      cmd_misaligned = is_misaligned(size, addr[1:0]);
      accept         = (state == ST_IDLE) && cmd && !cmd_misaligned;
      timeout_hit    = (state == ST_ACCESS) && !bus_ack && (wait_cnt == CNT_LAST);
      case (size)
         SZ_BYTE: begin
            be_next    = 4'b0001 << addr[1:0];
            wdata_next = {4{wdata[7:0]}};
         end
         SZ_HALF: begin
            be_next    = 4'b0011 << addr[1:0];
            wdata_next = {2{wdata[15:0]}};
         end
         default: begin
            be_next    = 4'b1111;
            wdata_next = wdata;
         end
      endcase
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:   if (accept) state_next = ST_ACCESS;
         ST_ACCESS: begin
            if (bus_ack)          state_next = ST_DONE;
            else if (timeout_hit) state_next = ST_IDLE;
         end
         ST_DONE:   state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_next;
   end

   // Lane, size and extension mode are latched so the load result does not
   // depend on upstream still holding its inputs during the ack cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wait_cnt    <= '0;
         bus_we      <= 1'b0;
         bus_addr    <= '0;
         bus_be      <= '0;
         bus_wdata   <= '0;
         lane_q      <= '0;
         size_q      <= '0;
         unsigned_q  <= 1'b0;
         load_data   <= '0;
         bus_timeout <= 1'b0;
      end else begin
         bus_timeout <= timeout_hit;
         if (accept) begin
            wait_cnt   <= '0;
            bus_we     <= ~mem_read;
            bus_addr   <= {addr[31:2], 2'b00};
            bus_be     <= be_next;
            bus_wdata  <= wdata_next;
            lane_q     <= addr[1:0];
            size_q     <= size;
            unsigned_q <= is_unsigned;
         end else if ((state == ST_ACCESS) && !bus_ack) begin
            wait_cnt <= wait_cnt + 8'd1;
         end
         if ((state == ST_ACCESS) && bus_ack && !bus_we) load_data <= aligned_rdata;
         else if (timeout_hit)                             load_data <= '0;
      end
   end

   load_align u_load_align (
      .bus_rdata   (bus_rdata),
      .addr_lo     (lane_q),
      .size        (size_q),
      .is_unsigned (unsigned_q),
      .result      (aligned_rdata)
   );

   // bus_req follows the state register, so reset removes it asynchronously.
   // stall and misaligned are gated by reset_n so they read 0 while reset is
   // held even if upstream still presents a command.
   always_comb begin
      bus_req    = (state == ST_ACCESS);
      done       = (state == ST_DONE);
      misaligned = reset_n && (state == ST_IDLE) && cmd && cmd_misaligned;
      stall      = reset_n && (accept || (state == ST_ACCESS));
   end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        mem_read, mem_write, is_unsigned;
   logic [1:0]  size;
   logic [31:0] addr, wdata;
   logic        bus_req, bus_we, bus_ack;
   logic [31:0] bus_addr, bus_wdata, bus_rdata, load_data;
   logic [3:0]  bus_be;
   logic        stall, done, misaligned, bus_timeout;

   always #5 clk = ~clk;

   mem_access_unit #(.TIMEOUT(TO)) dut (
      .clk(clk), .reset_n(reset_n), .mem_read(mem_read), .mem_write(mem_write),
      .size(size), .is_unsigned(is_unsigned), .addr(addr), .wdata(wdata),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
      .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
      .stall(stall), .load_data(load_data), .done(done),
      .misaligned(misaligned), .bus_timeout(bus_timeout)
   );

   // kind: 0 = completed access, 1 = misaligned reject, 2 = timeout abort
   typedef struct {
      int          kind;
      logic        we;
      logic [31:0] baddr;
      logic [3:0]  be;
      logic [31:0] bwd;
      logic [31:0] ld;
      int          reqc;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] model_ld = '0;
   logic        exp_stall = 1'b0;
   int          req_count = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_cmd();
      mem_read  = 1'b0;
      mem_write = 1'b0;
   endtask

   // Monitor: samples on the falling edge, checks bus fields against the
   // pending expectation and pops it on every done/misaligned/timeout pulse.
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (!reset_n) begin
         req_count = 0;
      end else begin
         chk("stall", {31'b0, stall}, {31'b0, exp_stall});
         if (bus_req) begin
            req_count++;
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL bus_req_unexpected actual=1 required=0");
            end else begin
               chk("bus_we", {31'b0, bus_we}, {31'b0, exp_q[0].we});
               chk("bus_addr", bus_addr, exp_q[0].baddr);
               chk("bus_be", {28'b0, bus_be}, {28'b0, exp_q[0].be});
               if (exp_q[0].we) chk("bus_wdata", bus_wdata, exp_q[0].bwd);
            end
         end
         if (done || misaligned || bus_timeout) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL event_unexpected actual=%b%b%b required=000", done, misaligned, bus_timeout);
            end else begin
               e = exp_q.pop_front();
               chk("done", {31'b0, done}, (e.kind == 0) ? 32'd1 : 32'd0);
               chk("misaligned", {31'b0, misaligned}, (e.kind == 1) ? 32'd1 : 32'd0);
               chk("bus_timeout", {31'b0, bus_timeout}, (e.kind == 2) ? 32'd1 : 32'd0);
               chk("load_data", load_data, e.ld);
               chk("req_cycles", req_count, e.reqc);
               req_count = 0;
            end
         end
      end
   end

   // One command from the execute stage, with this bench acting as the memory.
   // ack_at = N acknowledges in the Nth request cycle; 0 never acknowledges.
   task automatic run(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                      input int ack_at, input bit late_ack);
      exp_t            e;
      int              nb, off;
      bit              mis;
      longint unsigned v, mask;
      nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      off = int'(a[1:0]);
      mis = (off % nb) != 0;
      e.we    = !rd;
      e.baddr = {a[31:2], 2'b00};
      e.be    = '0;
      if (!mis) for (int i = 0; i < nb; i++) e.be[off + i] = 1'b1;
      for (int i = 0; i < 4; i++) e.bwd[8*i +: 8] = wd[8*(i % nb) +: 8];
      mask = (64'd1 << (8 * nb)) - 64'd1;
      v    = (64'(rdat) >> (8 * off)) & mask;
      if (!uns && v[8*nb-1]) v = v | ~mask;

      mem_read = rd; mem_write = wr; size = sz; is_unsigned = uns; addr = a; wdata = wd;
      bus_ack  = 1'b0;
      if (mis) begin
         e.kind = 1; e.ld = model_ld; e.reqc = 0;
         exp_stall = 1'b0;
         exp_q.push_back(e);
         step();
         clear_cmd();
         return;
      end
      exp_stall = 1'b1;
      if (ack_at == 0) begin
         model_ld = '0;
         e.kind = 2; e.ld = '0; e.reqc = TO;
      end else begin
         if (rd) model_ld = v[31:0];
         e.kind = 0; e.ld = model_ld; e.reqc = ack_at;
      end
      exp_q.push_back(e);
      step();
      if (ack_at > 0) begin
         for (int n = 1; n <= ack_at; n++) begin
            if (n == ack_at) begin
               bus_ack = 1'b1; bus_rdata = rdat;
            end else begin
               bus_rdata = $urandom;
            end
            step();
            bus_ack = 1'b0;
         end
         clear_cmd();
         exp_stall = 1'b0;
         step();
      end else begin
         for (int n = 1; n <= TO; n++) step();
         clear_cmd();
         exp_stall = 1'b0;
         if (late_ack) begin
            bus_ack = 1'b1; bus_rdata = rdat;
         end
         step();
         bus_ack = 1'b0;
      end
   endtask

   initial begin
      reset_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; size = 2'd0; is_unsigned = 1'b0;
      addr = '0; wdata = '0; bus_ack = 1'b0; bus_rdata = '0;
      #3;
      chk("rst_bus_req", {31'b0, bus_req}, 32'd0);
      chk("rst_bus_be", {28'b0, bus_be}, 32'd0);
      chk("rst_bus_addr", bus_addr, 32'd0);
      chk("rst_load_data", load_data, 32'd0);
      chk("rst_pulses", {29'b0, done, misaligned, bus_timeout}, 32'd0);
      step(); step();
      reset_n = 1'b1;
      step();

      run(1, 0, 2'd2, 0, 32'h100, 32'h0, 32'hDEADBEEF, 2, 0);
      run(1, 0, 2'd0, 0, 32'h203, 32'h0, 32'h80FF1234, 1, 0);
      run(1, 0, 2'd0, 1, 32'h203, 32'h0, 32'h80FF1234, 3, 0);
      run(0, 1, 2'd1, 0, 32'h42, 32'h0000ABCD, 32'h0, 1, 0);
      run(1, 0, 2'd2, 0, 32'h102, 32'h0, 32'h0, 1, 0);
      run(1, 1, 2'd1, 0, 32'h2E, 32'h12345678, 32'h8001_7FFF, 4, 0);

      // asynchronous reset in the middle of an access
      mem_read = 1'b1; size = 2'd2; addr = 32'h300; exp_stall = 1'b1;
      step();
      chk("pre_reset_bus_req", {31'b0, bus_req}, 32'd1);
      #1 reset_n = 1'b0;
      #1;
      chk("mid_reset_bus_req", {31'b0, bus_req}, 32'd0);
      chk("mid_reset_bus_fields", {bus_we, bus_be, bus_addr[26:0]}, 32'd0);
      chk("mid_reset_bus_wdata", bus_wdata, 32'd0);
      chk("mid_reset_load_data", load_data, 32'd0);
      chk("mid_reset_outs", {28'b0, stall, done, misaligned, bus_timeout}, 32'd0);
      model_ld = '0;
      clear_cmd();
      exp_stall = 1'b0;
      step(); step();
      reset_n = 1'b1;
      step();
      run(1, 0, 2'd3, 0, 32'h400, 32'h0, 32'hCAFEF00D, 1, 0);

      // timeout with a late acknowledge in the abort cycle
      run(1, 0, 2'd2, 0, 32'h500, 32'h0, 32'h11111111, 0, 1);
      step(); step();

      for (int t = 0; t < 200; t++) begin
         logic        rd, wr, uns, late;
         logic [1:0]  sz;
         logic [31:0] a;
         int          sel, ack;
         sel = int'($urandom_range(0, 3));
         rd  = (sel != 1);
         wr  = (sel == 1) || (sel == 2);
         sz  = 2'($urandom_range(0, 3));
         uns = 1'($urandom);
         a   = $urandom;
         if ($urandom_range(0, 3) != 0) a[1:0] = (sz == 2'd0) ? a[1:0] : (sz == 2'd1) ? {a[1], 1'b0} : 2'b00;
         ack  = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, TO));
         late = 1'($urandom);
         run(rd, wr, sz, uns, a, $urandom, $urandom, ack, late);
         if ($urandom_range(0, 2) == 0) step();
      end

      step(); step();
      chk("queue_empty", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
